// File: rtl/mem_responder_pkg.sv
// Shared types for the 6502 bus RAM responder: FSM encoding and the
// read-data drive-enable helper.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_DATA = 2'd2
    } rsp_state_t;

    // Condition bits for driving read data: {hit, rw, address match}.
    localparam int unsigned DRV_COND_W = 3;

    function automatic logic drive_ok(input logic [DRV_COND_W-1:0] cond);
        return &cond;
    endfunction

endpackage

// File: rtl/mem_responder_sync_ram.sv
// Single-port synchronous byte RAM; read data appears one ph0 edge after the
// address. Storage is not reset so contents survive a bus reset.
module sync_ram #(
    parameter int unsigned ADDR_BITS = 11
) (
    input  logic                 ph0,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 we,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem_q [2**ADDR_BITS];

    // Storage write and registered read port.
    always_ff @(posedge ph0) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// RAM target on the 6502 external bus: decodes a window, absorbs writes in
// one cycle and stalls reads with rdy until RAM data is registered.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned ADDR_BITS   = 11,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        ph0,
    input  logic        reset_n,
    input  logic [15:0] a,
    input  logic        rw,
    inout  wire  [7:0]  d,
    output logic        rdy,
    output logic        hit
);

    localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

    rsp_state_t           state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [15:0]          addr_q, addr_d;
    logic [7:0]           rdata_q, rdata_d;
    logic [ADDR_BITS-1:0] ram_addr_s;
    logic                 ram_we_s;
    logic [7:0]           ram_rdata_s;
    logic [7:0]           dout_s;
    logic                 match_s;
    logic                 drive_s;

    assign hit     = (a[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
    assign match_s = hit & rw & (a == addr_q);

    // Once a read is latched the RAM keeps reading addr_q so its output holds.
    assign ram_addr_s = (state_q == RSP_IDLE) ? a[ADDR_BITS-1:0] : addr_q[ADDR_BITS-1:0];
    assign ram_we_s   = reset_n & (state_q == RSP_IDLE) & hit & ~rw;

    // With no wait states rdata_q is never loaded, so serve the RAM output directly.
    assign dout_s = (WAIT_STATES == 32'd0) ? ram_rdata_s : rdata_q;
    assign d      = drive_s ? dout_s : 8'hzz;

    sync_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .ph0   (ph0),
        .addr  (ram_addr_s),
        .we    (ram_we_s),
        .wdata (d),
        .rdata (ram_rdata_s)
    );

    // State and datapath registers.
    always_ff @(posedge ph0 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RSP_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'h0000;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        case (state_q)
            RSP_IDLE: begin
                if (hit && rw) begin
                    addr_d  = a;
                    cnt_d   = WS_INIT;
                    state_d = (WAIT_STATES == 32'd0) ? RSP_DATA : RSP_WAIT;
                end else begin
                    state_d = RSP_IDLE;
                end
            end
            RSP_WAIT: begin
                rdata_d = ram_rdata_s;
                cnt_d   = cnt_q - 3'd1;
                if (!match_s) begin
                    state_d = RSP_IDLE;
                end else if (cnt_q == 3'd1) begin
                    state_d = RSP_DATA;
                end else begin
                    state_d = RSP_WAIT;
                end
            end
            RSP_DATA: begin
                state_d = RSP_IDLE;
            end
            default: begin
                state_d = RSP_IDLE;
            end
        endcase
    end

    // Bus outputs; reset overrides everything so the CPU is never held.
    always_comb begin
        rdy     = 1'b1;
        drive_s = 1'b0;
        if (!reset_n) begin
            rdy     = 1'b1;
            drive_s = 1'b0;
        end else begin
            case (state_q)
                RSP_IDLE: rdy = ~(hit & rw);
                RSP_WAIT: rdy = ~match_s;
                RSP_DATA: begin
                    rdy     = 1'b1;
                    drive_s = drive_ok({hit, rw, (a == addr_q)});
                end
                default:  rdy = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: four responders on one shared address/control bus, each on
// its own pulled-up data net so a released bus reads as 8'hFF.
module tb_mem_responder;

    logic        ph0;
    logic        reset_n;
    logic [15:0] a;
    logic        rw;
    logic [7:0]  wdata;
    logic        wr_oe;
    logic [3:0]  rdy_v;
    logic [3:0]  hit_v;
    tri1  [7:0]  d_a, d_b, d_c, d_d;

    int n_checks = 0;
    int n_fail   = 0;

    assign d_a = wr_oe ? wdata : 8'hzz;
    assign d_b = wr_oe ? wdata : 8'hzz;
    assign d_c = wr_oe ? wdata : 8'hzz;
    assign d_d = wr_oe ? wdata : 8'hzz;

    mem_responder #(.BASE_ADDR(16'h0000), .ADDR_BITS(11), .WAIT_STATES(1)) u_dut_a (
        .ph0(ph0), .reset_n(reset_n), .a(a), .rw(rw), .d(d_a), .rdy(rdy_v[0]), .hit(hit_v[0]));
    mem_responder #(.BASE_ADDR(16'h0000), .ADDR_BITS(11), .WAIT_STATES(3)) u_dut_b (
        .ph0(ph0), .reset_n(reset_n), .a(a), .rw(rw), .d(d_b), .rdy(rdy_v[1]), .hit(hit_v[1]));
    mem_responder #(.BASE_ADDR(16'h0000), .ADDR_BITS(11), .WAIT_STATES(0)) u_dut_c (
        .ph0(ph0), .reset_n(reset_n), .a(a), .rw(rw), .d(d_c), .rdy(rdy_v[2]), .hit(hit_v[2]));
    mem_responder #(.BASE_ADDR(16'h8000), .ADDR_BITS(11), .WAIT_STATES(1)) u_dut_d (
        .ph0(ph0), .reset_n(reset_n), .a(a), .rw(rw), .d(d_d), .rdy(rdy_v[3]), .hit(hit_v[3]));

    initial ph0 = 1'b0;
    always #5 ph0 = ~ph0;

    function automatic logic [7:0] d_sel(input logic [1:0] s);
        case (s)
            2'd0:    return d_a;
            2'd1:    return d_b;
            2'd2:    return d_c;
            default: return d_d;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ph0);
        #1;
    endtask

    task automatic bus(input logic [15:0] addr, input logic r, input logic [7:0] wd);
        a     = addr;
        rw    = r;
        wdata = wd;
        wr_oe = ~r;
    endtask

    task automatic idle();
        bus(16'hF000, 1'b1, 8'h00);
    endtask

    task automatic do_write(input logic [1:0] s, input logic [15:0] addr, input logic [7:0] data);
        bus(addr, 1'b0, data);
        @(negedge ph0);
        check_eq("wr_rdy", 16'(rdy_v[s]), 16'h0001);
        step();
        idle();
    endtask

    // Holds a read until rdy rises; counts stall cycles and checks the bus stays released.
    task automatic do_read(input logic [1:0] s, input logic [15:0] addr,
                           input logic [7:0] exp, input int exp_stalls);
        int  stalls = 0;
        bit  done   = 1'b0;
        bus(addr, 1'b1, 8'h00);
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge ph0);
            if (rdy_v[s]) begin
                done = 1'b1;
            end else begin
                check_eq("stall_bus_free", 16'(d_sel(s)), 16'h00FF);
                stalls++;
                step();
            end
        end
        check_eq("rd_done", 16'(done), 16'h0001);
        check_eq("rd_stalls", 16'(stalls), 16'(exp_stalls));
        check_eq("rd_data", 16'(d_sel(s)), 16'(exp));
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        bus(16'h0123, 1'b1, 8'h00);
        #3;
        check_eq("rst_rdy", 16'(rdy_v[0]), 16'h0001);
        check_eq("rst_bus", 16'(d_a), 16'h00FF);
        check_eq("rst_hit", 16'(hit_v[0]), 16'h0001);
        idle();
        step();
        reset_n = 1'b1;

        // Basic write then read, one wait state.
        do_write(2'd0, 16'h0123, 8'hA5);
        do_read(2'd0, 16'h0123, 8'hA5, 2);
        idle();
        @(negedge ph0);
        check_eq("post_rd_bus", 16'(d_a), 16'h00FF);
        step();

        // Zero wait states and the top-of-window boundary.
        do_write(2'd2, 16'h07FF, 8'h3C);
        do_read(2'd2, 16'h07FF, 8'h3C, 1);
        bus(16'h0800, 1'b1, 8'h00);
        @(negedge ph0);
        check_eq("c_nohit_hit", 16'(hit_v[2]), 16'h0000);
        check_eq("c_nohit_rdy", 16'(rdy_v[2]), 16'h0001);
        check_eq("c_nohit_bus", 16'(d_c), 16'h00FF);
        step();
        idle();

        // Window at 0x8000 and its alias below.
        do_write(2'd3, 16'h8005, 8'h11);
        do_read(2'd3, 16'h8005, 8'h11, 2);
        bus(16'h0005, 1'b1, 8'h00);
        @(negedge ph0);
        check_eq("d_alias_hit", 16'(hit_v[3]), 16'h0000);
        check_eq("d_alias_rdy", 16'(rdy_v[3]), 16'h0001);
        check_eq("d_alias_bus", 16'(d_d), 16'h00FF);
        step();
        bus(16'h87FF, 1'b1, 8'h00);
        #1;
        check_eq("d_hit_top", 16'(hit_v[3]), 16'h0001);
        bus(16'h8800, 1'b1, 8'h00);
        #1;
        check_eq("d_hit_above", 16'(hit_v[3]), 16'h0000);
        idle();
        step();

        // Abort by address change, then by a write, three wait states.
        do_write(2'd1, 16'h0010, 8'h77);
        do_write(2'd1, 16'h0020, 8'h99);
        bus(16'h0010, 1'b1, 8'h00);
        @(negedge ph0);
        check_eq("b_rd_stall", 16'(rdy_v[1]), 16'h0000);
        step();
        bus(16'h0020, 1'b1, 8'h00);
        @(negedge ph0);
        check_eq("abort_rdy", 16'(rdy_v[1]), 16'h0001);
        check_eq("abort_bus", 16'(d_b), 16'h00FF);
        step();
        do_read(2'd1, 16'h0020, 8'h99, 4);
        bus(16'h0010, 1'b1, 8'h00);
        @(negedge ph0);
        check_eq("b_rd_stall2", 16'(rdy_v[1]), 16'h0000);
        step();
        bus(16'h0020, 1'b0, 8'h55);
        @(negedge ph0);
        check_eq("abort_wr_rdy", 16'(rdy_v[1]), 16'h0001);
        step();
        do_read(2'd1, 16'h0020, 8'h99, 4);
        do_read(2'd1, 16'h0010, 8'h77, 4);
        idle();
        step();

        // Reset asserted while a read is waiting.
        do_write(2'd0, 16'h0040, 8'h5A);
        bus(16'h0040, 1'b1, 8'h00);
        @(negedge ph0);
        check_eq("a_rd_stall", 16'(rdy_v[0]), 16'h0000);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_rdy", 16'(rdy_v[0]), 16'h0001);
        check_eq("midrst_bus", 16'(d_a), 16'h00FF);
        step();
        check_eq("rst_hold_rdy", 16'(rdy_v[0]), 16'h0001);
        reset_n = 1'b1;
        do_read(2'd0, 16'h0040, 8'h5A, 2);
        idle();
        step();

        // Back-to-back reads with no idle cycle between them.
        do_write(2'd0, 16'h0001, 8'h01);
        do_write(2'd0, 16'h0002, 8'h02);
        do_read(2'd0, 16'h0001, 8'h01, 2);
        do_read(2'd0, 16'h0002, 8'h02, 2);
        idle();
        @(negedge ph0);
        check_eq("b2b_released", 16'(d_a), 16'h00FF);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-mapped RAM target on the 6502 external bus; the responder at the far end of the CPU's a/d/rw pins.
- Decodes the address, captures write cycles, and serves read cycles from a synchronous RAM.
- Read-data latency is hidden by pulling rdy low until data is ready.
- Instantiated at system level beside the CPU core.

Parameters:
- BASE_ADDR, 16'h0000, base of the decoded window; bits below ADDR_BITS are ignored.
- ADDR_BITS, 11, RAM address width (2 KiB); legal range 4..15.
- WAIT_STATES, 1, extra stall cycles per read; legal range 0..7.

Ports:
- ph0  input  1  sole clock; one bus cycle per ph0 period, all flops on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- a  input  16  CPU address bus.
- rw  input  1  1 = read, 0 = write.
- d  inout  8  CPU data bus; driven only when serving read data, else high-Z.
- rdy  output  1  CPU ready; 0 holds the CPU on the current read cycle.
- hit  output  1  combinational window decode, for debug and external bus arbitration.

Behaviour:
- Bus contract: a, rw and (on writes) d are stable at the rising ph0 edge that closes the cycle.
- hit = (a[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]).
- State machine (rsp_state_t): RSP_IDLE, RSP_WAIT, RSP_DATA.
- Registers: state, 3-bit wait counter cnt, latched address addr_q, read-data register rdata_q.
- Reset (async, reset_n = 0): state = RSP_IDLE, cnt = 0, addr_q = 0, rdata_q = 0.
  - While reset_n = 0, rdy = 1 and d = Z.
  - RAM contents are preserved across reset.
- RSP_IDLE:
  - Read hit: rdy = 0 combinationally in the same cycle. At the closing edge: RAM read issued at a[ADDR_BITS-1:0], addr_q <= a, cnt <= WAIT_STATES, next state = (WAIT_STATES == 0) ? RSP_DATA : RSP_WAIT.
  - Write hit: rdy = 1; RAM written with d at the closing edge; stay in RSP_IDLE; writes never stall.
  - No hit: rdy = 1, d = Z, no RAM access.
- RSP_WAIT:
  - rdy = 0.
  - Each edge decrements cnt; RAM output is captured into rdata_q each edge.
  - cnt == 1 at an edge: go to RSP_DATA.
- RSP_DATA:
  - rdy = 1; d driven with rdata_q while hit & rw & (a == addr_q).
  - Closing edge returns to RSP_IDLE.
- Read cost: 2 + WAIT_STATES bus cycles. Write cost: 1 bus cycle.
- Abort: in RSP_WAIT or RSP_DATA, if !(hit & rw & a == addr_q):
  - rdy = 1 and d = Z immediately.
  - Next edge returns to RSP_IDLE; no RAM write happens on that edge.
  - The current cycle is not re-decoded as a new access.
- Back-to-back reads: RSP_DATA → RSP_IDLE, so the following read hit stalls again. No data is forwarded between reads.
- Read immediately after a write to the same address returns the new data (RAM write occurs before the read is issued).
- Address wrap: only a[ADDR_BITS-1:0] indexes the RAM; addresses outside the window never touch it.
- Reset asserted mid-read: state drops to RSP_IDLE at once, rdy = 1, d released.

Decomposition:
- Shared package holds:
  - rsp_state_t enum (RSP_IDLE, RSP_WAIT, RSP_DATA).
  - Localparam for the RSP_DATA drive-enable condition helper width.
- One sub-module, sync_ram:
  - Parameter ADDR_BITS; single port, clocked on ph0.
  - Ports: addr, we, wdata, rdata.
  - rdata registered one edge after addr; no reset on the storage array.

Test Plan:
- Reset, then write 8'hA5 to 16'h0123 (1 cycle, rdy stays 1); read 16'h0123 with WAIT_STATES=1 → rdy low for 2 cycles, third cycle d = 8'hA5 with rdy = 1.
- WAIT_STATES=0: write 8'h3C to 16'h07FF, then read it → rdy low for exactly 1 cycle, then d = 8'h3C; read of 16'h0800 → hit = 0, rdy = 1, d = Z.
- Window/alias: BASE_ADDR=16'h8000, ADDR_BITS=11; write 8'h11 to 16'h8005; read 16'h8005 → 8'h11; read 16'h0005 → no hit, d = Z.
- Abort: start read of 16'h0010 (WAIT_STATES=3), change a to 16'h0020 during RSP_WAIT → rdy = 1 and d = Z in that cycle, state RSP_IDLE next edge, RAM unchanged.
- Reset mid-read: assert reset_n = 0 while in RSP_WAIT → rdy = 1 and d = Z without a clock edge; after release, a prior write of 8'h5A to 16'h0040 still reads back 8'h5A.
- Back-to-back: reads of 16'h0001 then 16'h0002 (values 8'h01/8'h02) → each stalls 1 + WAIT_STATES cycles; correct data on each, no stale rdata_q drive.
